// File: rtl/scpu_pkg.sv
// Shared definitions for the single-cycle core: memory-op encoding used by the
// control decoder and the load/store unit, plus the LSU state type.
package scpu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] MOP_B  = 3'b000;
    localparam logic [2:0] MOP_H  = 3'b001;
    localparam logic [2:0] MOP_W  = 3'b010;
    localparam logic [2:0] MOP_BU = 3'b100;
    localparam logic [2:0] MOP_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT,
        LSU_DONE
    } lsu_state_t;

    // Unsigned variants only exist for loads; 011/110/111 are unused encodings.
    function automatic logic mop_illegal(input logic write, input logic [2:0] op);
        return (op == 3'b011) || (op[2:1] == 2'b11) || (write && op[2]);
    endfunction

endpackage

// File: rtl/scpu_lsu_align.sv
// Combinational datapath for the LSU: store lane steering and byte enables,
// load shift/extension, and the misalignment / illegal-op check.
module scpu_lsu_align
    import scpu_pkg::*;
(
    input  logic            write,
    input  logic [2:0]      op,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic            err,
    output logic [XLEN-1:0] st_data,
    output logic [3:0]      st_mask,
    output logic [XLEN-1:0] ld_data
);

    logic            misaligned;
    logic [XLEN-1:0] shifted;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        misaligned = 1'b0;
        if (op[1:0] == 2'b01) begin
            misaligned = addr_lo[0];
        end else if (op[1:0] == 2'b10) begin
            misaligned = (addr_lo != 2'b00);
        end
        err = mop_illegal(write, op) || misaligned;
    end

    always_comb begin
        st_data = wdata;
        st_mask = 4'b1111;
        case (op[1:0])
            2'b00: begin
                st_data = {24'b0, wdata[7:0]} << {addr_lo, 3'b000};
                st_mask = 4'b0001 << addr_lo;
            end
            2'b01: begin
                st_data = addr_lo[1] ? {wdata[15:0], 16'b0} : {16'b0, wdata[15:0]};
                st_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        ld_data = rdata;
        case (op)
            MOP_B:   ld_data = {{24{shifted[7]}}, shifted[7:0]};
            MOP_BU:  ld_data = {24'b0, shifted[7:0]};
            MOP_H:   ld_data = {{16{shifted[15]}}, shifted[15:0]};
            MOP_HU:  ld_data = {16'b0, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/scpu_lsu.sv
// Load/store unit: accepts one memory op from execute, runs it on a
// valid/ready word bus and returns extended load data or a store acknowledge.
module scpu_lsu
    import scpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wmask,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_rdata
);

    lsu_state_t      state;
    logic            idle;
    logic            r_write;
    logic [2:0]      r_op;
    logic [1:0]      r_addr_lo;

    logic            a_write;
    logic [2:0]      a_op;
    logic [1:0]      a_addr_lo;
    logic            a_err;
    logic [XLEN-1:0] a_st_data;
    logic [3:0]      a_st_mask;
    logic [XLEN-1:0] a_ld_data;

    assign idle      = (state == LSU_IDLE);
    assign req_ready = idle;

    // The aligner sees the incoming request while idle and the latched one afterwards.
    assign a_write   = idle ? req_write     : r_write;
    assign a_op      = idle ? req_op        : r_op;
    assign a_addr_lo = idle ? req_addr[1:0] : r_addr_lo;

    scpu_lsu_align u_align (
        .write   (a_write),
        .op      (a_op),
        .addr_lo (a_addr_lo),
        .wdata   (req_wdata),
        .rdata   (mem_rdata),
        .err     (a_err),
        .st_data (a_st_data),
        .st_mask (a_st_mask),
        .ld_data (a_ld_data)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= LSU_IDLE;
            r_write       <= 1'b0;
            r_op          <= MOP_B;
            r_addr_lo     <= 2'b00;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wmask     <= 4'b0000;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_err      <= 1'b0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (req_valid) begin
                        r_write    <= req_write;
                        r_op       <= req_op;
                        r_addr_lo  <= req_addr[1:0];
                        mem_addr   <= {req_addr[XLEN-1:2], 2'b00};
                        mem_we     <= req_write;
                        mem_wdata  <= req_write ? a_st_data : '0;
                        mem_wmask  <= req_write ? a_st_mask : 4'b0000;
                        resp_rdata <= '0;
                        resp_err   <= a_err;
                        if (a_err) begin
                            resp_valid <= 1'b1;
                            state      <= LSU_DONE;
                        end else begin
                            mem_req_valid <= 1'b1;
                            state         <= LSU_REQ;
                        end
                    end
                end
                LSU_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= LSU_WAIT;
                    end
                end
                LSU_WAIT: begin
                    if (mem_resp_valid) begin
                        if (!r_write) begin
                            resp_rdata <= a_ld_data;
                        end
                        resp_valid <= 1'b1;
                        state      <= LSU_DONE;
                    end
                end
                LSU_DONE: begin
                    resp_valid <= 1'b0;
                    state      <= LSU_IDLE;
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scpu_lsu.sv
// Directed bench for scpu_lsu: a vector table of single transactions against a
// simple bus responder, plus hand sequences for reset behaviour.
module tb_scpu_lsu;
    import scpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    scpu_lsu dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        write;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          rdy_dly;
        int          rsp_dly;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_mask;
        int          exp_lat;
    } vec_t;

    function automatic vec_t mk(input logic write, input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input int rdy_dly, input int rsp_dly, input logic exp_err,
                                input logic [31:0] exp_rdata, input logic [31:0] exp_wdata,
                                input logic [3:0] exp_mask, input int exp_lat);
        vec_t v;
        v.write = write; v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.rdy_dly = rdy_dly; v.rsp_dly = rsp_dly; v.exp_err = exp_err;
        v.exp_rdata = exp_rdata; v.exp_wdata = exp_wdata; v.exp_mask = exp_mask;
        v.exp_lat = exp_lat;
        return v;
    endfunction

    function automatic logic [31:0] lane_bits(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // Observations from the most recent transaction.
    int          resp_t;
    int          n_pulse;
    logic [31:0] o_rdata;
    logic        o_err;
    logic        hold_ok;
    logic        ready_after;
    logic        req_seen;
    logic        req_stable;
    logic [31:0] o_addr;
    logic        o_we;
    logic [31:0] o_wdata;
    logic [3:0]  o_mask;

    // Called at a negedge; returns at a negedge two idle cycles after the response.
    task automatic run_txn(input vec_t v);
        int   req_cnt;
        int   wait_cnt;
        logic hs_done;
        resp_t = -1; n_pulse = 0; hold_ok = 1'b1; ready_after = 1'b0;
        req_seen = 1'b0; req_stable = 1'b1;
        req_cnt = 0; wait_cnt = 0; hs_done = 1'b0;
        req_valid = 1'b1;
        req_write = v.write;
        req_op    = v.op;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        mem_rdata = ~v.rdata;
        for (int t = 1; t <= 60; t++) begin
            @(negedge clk);
            req_valid      = 1'b0;
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            mem_rdata      = ~v.rdata;
            if (resp_t >= 0 && t > resp_t + 2) break;
            if (resp_valid) begin
                n_pulse++;
                if (resp_t < 0) begin
                    resp_t  = t;
                    o_rdata = resp_rdata;
                    o_err   = resp_err;
                end
            end
            if (resp_t >= 0 && t > resp_t) begin
                if (resp_rdata !== o_rdata || resp_err !== o_err) hold_ok = 1'b0;
                if (t == resp_t + 1) ready_after = req_ready;
            end
            if (mem_req_valid) begin
                if (!req_seen) begin
                    o_addr = mem_addr; o_we = mem_we; o_wdata = mem_wdata; o_mask = mem_wmask;
                end else if (mem_addr !== o_addr || mem_we !== o_we ||
                             mem_wdata !== o_wdata || mem_wmask !== o_mask) begin
                    req_stable = 1'b0;
                end
                req_seen = 1'b1;
                req_cnt++;
                if (req_cnt > v.rdy_dly) begin
                    mem_req_ready = 1'b1;
                    hs_done       = 1'b1;
                end
            end else if (hs_done && resp_t < 0) begin
                wait_cnt++;
                if (wait_cnt > v.rsp_dly) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata      = v.rdata;
                end
            end
        end
    endtask

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_op = MOP_W;
        req_addr = '0; req_wdata = '0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_rdata = '0;

        //                 wr    op      addr          wdata         rdata         rdy rsp err  exp_rdata     exp_wdata     mask     lat
        vecs.push_back(mk(1'b0, MOP_W,  32'h8000_0004, 32'h0,        32'hDEAD_BEEF, 0, 0, 1'b0, 32'hDEAD_BEEF, 32'h0,       4'b0000, 3));
        vecs.push_back(mk(1'b0, MOP_B,  32'h8000_0003, 32'h0,        32'h80FF_1234, 0, 0, 1'b0, 32'hFFFF_FF80, 32'h0,       4'b0000, 3));
        vecs.push_back(mk(1'b0, MOP_BU, 32'h8000_0003, 32'h0,        32'h80FF_1234, 0, 0, 1'b0, 32'h0000_0080, 32'h0,       4'b0000, 3));
        vecs.push_back(mk(1'b1, MOP_H,  32'h8000_0002, 32'h1234_ABCD, 32'h5555_5555, 0, 0, 1'b0, 32'h0,       32'hABCD_0000, 4'b1100, 3));
        vecs.push_back(mk(1'b0, MOP_W,  32'h8000_0002, 32'h0,        32'h1111_1111, 0, 0, 1'b1, 32'h0,        32'h0,       4'b0000, 1));
        vecs.push_back(mk(1'b0, 3'b011, 32'h8000_0000, 32'h0,        32'h1111_1111, 0, 0, 1'b1, 32'h0,        32'h0,       4'b0000, 1));
        vecs.push_back(mk(1'b0, MOP_H,  32'h1000_0002, 32'h0,        32'h8001_7FFF, 0, 0, 1'b0, 32'hFFFF_8001, 32'h0,       4'b0000, 3));
        vecs.push_back(mk(1'b0, MOP_HU, 32'h1000_0000, 32'h0,        32'h8001_F00F, 0, 0, 1'b0, 32'h0000_F00F, 32'h0,       4'b0000, 3));
        vecs.push_back(mk(1'b0, MOP_H,  32'h1000_0001, 32'h0,        32'h1111_1111, 0, 0, 1'b1, 32'h0,        32'h0,       4'b0000, 1));
        vecs.push_back(mk(1'b1, MOP_B,  32'h3000_0001, 32'h0000_00A5, 32'h0,        0, 0, 1'b0, 32'h0,        32'h0000_A500, 4'b0010, 3));
        vecs.push_back(mk(1'b1, MOP_W,  32'h2000_0008, 32'hCAFE_F00D, 32'h0,        0, 0, 1'b0, 32'h0,        32'hCAFE_F00D, 4'b1111, 3));
        vecs.push_back(mk(1'b1, MOP_BU, 32'h2000_0000, 32'h0000_0011, 32'h0,        0, 0, 1'b1, 32'h0,        32'h0,       4'b0000, 1));
        vecs.push_back(mk(1'b0, 3'b111, 32'h2000_0000, 32'h0,        32'h0,        0, 0, 1'b1, 32'h0,        32'h0,       4'b0000, 1));
        vecs.push_back(mk(1'b0, MOP_B,  32'h4000_0001, 32'h0,        32'h0000_9A00, 0, 0, 1'b0, 32'hFFFF_FF9A, 32'h0,       4'b0000, 3));
        vecs.push_back(mk(1'b0, MOP_B,  32'h4000_0000, 32'h0,        32'h1234_567F, 0, 0, 1'b0, 32'h0000_007F, 32'h0,       4'b0000, 3));
        vecs.push_back(mk(1'b0, MOP_W,  32'h5000_0004, 32'h0,        32'h1234_5678, 5, 3, 1'b0, 32'h1234_5678, 32'h0,       4'b0000, 11));
        vecs.push_back(mk(1'b1, MOP_H,  32'h5000_0000, 32'h0000_BEEF, 32'h0,        2, 1, 1'b0, 32'h0,        32'h0000_BEEF, 4'b0011, 6));

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_req_ready",  32'(req_ready),     32'd1);
        check("rst_mem_req",    32'(mem_req_valid), 32'd0);
        check("rst_resp_valid", 32'(resp_valid),    32'd0);
        check("rst_resp_err",   32'(resp_err),      32'd0);
        check("rst_resp_rdata", resp_rdata,         32'h0);
        check("rst_wmask",      32'(mem_wmask),     32'h0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            logic [31:0] exp_addr;
            exp_addr = {vecs[i].addr[31:2], 2'b00};
            run_txn(vecs[i]);
            check($sformatf("v%0d_lat", i),    resp_t,             vecs[i].exp_lat);
            check($sformatf("v%0d_pulses", i), n_pulse,            32'd1);
            check($sformatf("v%0d_err", i),    32'(o_err),         32'(vecs[i].exp_err));
            check($sformatf("v%0d_rdata", i),  o_rdata,            vecs[i].exp_rdata);
            check($sformatf("v%0d_hold", i),   32'(hold_ok),       32'd1);
            check($sformatf("v%0d_ready", i),  32'(ready_after),   32'd1);
            check($sformatf("v%0d_reqseen", i), 32'(req_seen),     32'(!vecs[i].exp_err));
            if (!vecs[i].exp_err) begin
                check($sformatf("v%0d_addr", i),   o_addr,                      exp_addr);
                check($sformatf("v%0d_we", i),     32'(o_we),                   32'(vecs[i].write));
                check($sformatf("v%0d_mask", i),   32'(o_mask),                 32'(vecs[i].exp_mask));
                check($sformatf("v%0d_wdata", i),  o_wdata & lane_bits(vecs[i].exp_mask), vecs[i].exp_wdata);
                check($sformatf("v%0d_stable", i), 32'(req_stable),             32'd1);
            end
        end

        // Reset while a store waits for its ack, then a stray bus response.
        req_valid = 1'b1; req_write = 1'b1; req_op = MOP_W;
        req_addr = 32'h6000_0000; req_wdata = 32'h0BAD_F00D;
        @(negedge clk);
        req_valid = 1'b0;
        check("rw_req_valid", 32'(mem_req_valid), 32'd1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("rw_in_wait_mask", 32'(mem_wmask), 32'hF);
        check("rw_in_wait_ready", 32'(req_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rw_ready",  32'(req_ready),     32'd1);
        check("rw_mreq",   32'(mem_req_valid), 32'd0);
        check("rw_wmask",  32'(mem_wmask),     32'h0);
        check("rw_err",    32'(resp_err),      32'd0);
        check("rw_rdata",  resp_rdata,         32'h0);
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rw_stray_resp%0d", k),  32'(resp_valid), 32'd0);
            check($sformatf("rw_stray_ready%0d", k), 32'(req_ready),  32'd1);
        end
        mem_resp_valid = 1'b0;

        // The unit still works after the abandoned transaction.
        run_txn(vecs[0]);
        check("post_rst_lat",   resp_t,  32'd3);
        check("post_rst_rdata", o_rdata, 32'hDEAD_BEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/scpu_lsu.md
# scpu_lsu

Load/store unit for the single-cycle core. It takes a memory operation (mem_write, mem_op, address, store data) from the execute stage and runs it on a word-wide valid/ready data bus, then returns a sign- or zero-extended load result or a store acknowledge. It consumes the mem_write/mem_op encoding that the control decoder produces. It also handles byte-lane steering, write masks and misalignment detection.

## Interface
- No parameters; XLEN fixed at 32.
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  core presents an operation
- req_ready  out  1  LSU can accept; high only in IDLE
- req_write  in  1  1 = store, 0 = load (control mem_write)
- req_op  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu; others illegal
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or illegal op; valid with resp_valid
- mem_req_valid  out  1  bus request
- mem_req_ready  in  1  bus accepts request
- mem_we  out  1  bus write
- mem_addr  out  32  word address, {req_addr[31:2],2'b00}
- mem_wdata  out  32  lane-steered store data
- mem_wmask  out  4  byte enables; 0000 on reads
- mem_resp_valid  in  1  bus read data / write ack
- mem_rdata  in  32  bus read word

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: req_ready=1. When req_valid is high, latch write/op/addr/wdata. Run the check:
  - illegal op (011, 110, 111, or a store with op[2]=1);
  - h/hu with addr[0]=1;
  - w with addr[1:0]≠00.
- If the check fails, go to DONE with err=1 and make no bus access. Otherwise go to REQ.
- REQ: mem_req_valid=1. Address, we, wdata and mask stay stable until mem_req_ready. Then go to WAIT.
- WAIT: wait for mem_resp_valid. On a load, capture mem_rdata, shift right by addr[1:0]*8, then sign-extend (b, h) or zero-extend (bu, hu). Go to DONE.
- DONE: resp_valid=1 for one cycle, then IDLE.
- Store steering: byte writes place wdata[7:0] in lane addr[1:0] with mask 0001<<addr[1:0]. Half writes place wdata[15:0] in lanes at addr[1] with mask 0011 or 1100. Word writes use mask 1111.
- mem_resp_valid outside WAIT is ignored. mem_req_ready outside REQ is ignored.
- Reset (any state): state IDLE. mem_req_valid, resp_valid and resp_err are 0. resp_rdata is 0 and mem_wmask is 0000. A transaction in flight is abandoned and its late response is ignored.

## Timing
- All outputs except req_ready are registered. req_ready decodes from state (IDLE) only.
- Accepted at edge N gives mem_req_valid high from cycle N+1.
- With zero-wait bus (ready in N+1, resp in N+2), resp_valid is in cycle N+3.
- Misaligned or illegal op gives resp_valid in cycle N+1.
- resp_rdata and resp_err hold their values until the next acceptance.
- No back-to-back issue: the minimum spacing between acceptances is the transaction length plus one IDLE cycle.

## Structure
- Shared package scpu_pkg: mem_op localparams (MOP_B, MOP_H, MOP_W, MOP_BU, MOP_HU), reused by the control decoder.
- Sub-module scpu_lsu_align (combinational) provides store lane steering and mask generation, load shift and extension, and the alignment/illegal check. The FSM and registers stay in scpu_lsu.

## Test plan
- lw addr 0x8000_0004, mem_rdata 0xDEAD_BEEF, zero-wait bus -> mem_addr 0x8000_0004, mask 0000, resp_rdata 0xDEAD_BEEF, resp_valid 3 cycles after accept.
- lb at 0x…03, then lbu at 0x…03, mem_rdata 0x80FF_1234 -> 0xFFFF_FF80, then 0x0000_0080.
- sh addr 0x…02, wdata 0x1234_ABCD -> mem_wdata[31:16]=0xABCD, mask 1100, resp_rdata 0, err 0.
- lw at 0x…02, and op 011 -> resp_valid next cycle, err 1, mem_req_valid never asserted.
- mem_req_ready low 5 cycles, then mem_resp_valid delayed 3 cycles -> request fields stable throughout, single resp_valid pulse.
- rst asserted in WAIT, then stray mem_resp_valid -> IDLE, no resp_valid, req_ready 1.
